// File: rtl/wb_mux_stage.sv
// Write-back source selector with load extraction and a single valid/ready output register.
// Optional WB_PERF_CNT_EN adds wb_count/stall_count performance counters.
module wb_mux_stage #(
    parameter int DWIDTH = 32,
    parameter int NSRC = 4,
    localparam int SELW = $clog2(NSRC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NSRC*DWIDTH-1:0] src_data,
    input  logic [SELW-1:0]        sel,
    input  logic [1:0]             load_size,
    input  logic                   load_unsigned,
    input  logic [1:0]             byte_off,
    input  logic [4:0]             rd_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DWIDTH-1:0]      WD,
    output logic [4:0]             rd_out,
    output logic                   err,
    output logic [1:0]             err_code
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]            wb_count,
    output logic [31:0]            stall_count
`endif
);

    logic              accept;
    logic              sel_oob;
    logic              is_load;
    logic [DWIDTH-1:0] picked;
    logic [31:0]       lw;
    logic [7:0]        lb;
    logic [15:0]       lh;
    logic [DWIDTH-1:0] ld;
    logic [DWIDTH-1:0] nxt_wd;
    logic [1:0]        cur_code;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign sel_oob  = 32'(sel) >= 32'(NSRC);
    assign is_load  = (sel == SELW'(1));

    always_comb begin
        picked = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SELW'(k)) picked = src_data[k*DWIDTH +: DWIDTH];
        end
    end

    // Load extraction always works on the low word of source 1
    assign lw = src_data[DWIDTH +: 32];
    assign lb = lw[8*byte_off +: 8];
    assign lh = byte_off[1] ? lw[31:16] : lw[15:0];

    always_comb begin
        ld = '0;
        unique case (load_size)
            2'b00:   ld = load_unsigned ? DWIDTH'(lb) : DWIDTH'($signed(lb));
            2'b01:   ld = load_unsigned ? DWIDTH'(lh) : DWIDTH'($signed(lh));
            default: ld = load_unsigned ? DWIDTH'(lw) : DWIDTH'($signed(lw));
        endcase
    end

    always_comb begin
        nxt_wd = picked;
        if (sel_oob)      nxt_wd = '0;
        else if (is_load) nxt_wd = ld;
    end

    // Out-of-range select outranks any load-related cause
    always_comb begin
        cur_code = 2'b00;
        if (sel_oob) begin
            cur_code = 2'b01;
        end else if (is_load) begin
            if (load_size == 2'b11)
                cur_code = 2'b11;
            else if (load_size == 2'b01 && byte_off[0])
                cur_code = 2'b10;
            else if (load_size == 2'b10 && byte_off != 2'b00)
                cur_code = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            WD        <= '0;
            rd_out    <= '0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                WD        <= nxt_wd;
                rd_out    <= rd_in;
                if (!err && cur_code != 2'b00) begin
                    err      <= 1'b1;
                    err_code <= cur_code;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef WB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_count    <= '0;
            stall_count <= '0;
        end else if (out_valid) begin
            if (out_ready) wb_count    <= wb_count + 32'd1;
            else           stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
